run_controller: RTL and testbench

Synthesisable run controller that sequences one or more processor cores through reset and execution, then halts them on a pass signature or a cycle budget. It turns the fixed "pulse reset, run N cycles, stop" bench flow into a parametrised block for multi-core and FPGA bring-up. It sits between the top level and the cores. It drives each core's active-high `reset` and monitors each core's 32-bit `out` bus.

---
 rtl/run_controller_pkg.sv | 17 +
 rtl/run_controller_if.sv | 39 +++
 rtl/run_ch_monitor.sv | 40 ++++
 rtl/run_controller.sv | 154 +++++++++++++++
 tb/tb_run_controller.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/run_controller_pkg.sv
// run_controller shared types and default parameters.
// Imported by the interface, the channel monitor and the top.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RESET,
    RUN,
    DONE
  } run_state_e;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_NUM_CH     = 1;
  localparam int DEF_RST_CYCLES = 1;
  localparam int DEF_CNT_W      = 32;

endpackage

// File: rtl/run_controller_if.sv
// Control/status bundle between the top level and run_controller.
// master drives start/config/core_out, slave is the controller.
interface run_controller_if
  import run_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
);

  logic                     start;
  logic                     abort;
  logic [CNT_W-1:0]         max_cycles;
  logic [DATA_W-1:0]        pass_value;
  logic [NUM_CH-1:0]        ch_enable;
  logic [NUM_CH*DATA_W-1:0] core_out;
  logic                     core_reset;
  logic                     busy;
  logic                     done;
  logic                     pass;
  logic                     timeout;
  logic [NUM_CH-1:0]        pass_mask;
  logic [CNT_W-1:0]         cycle_count;

  modport master (
    output start, abort, max_cycles, pass_value,
    output ch_enable, core_out,
    input  core_reset, busy, done, pass, timeout,
    input  pass_mask, cycle_count
  );

  modport slave (
    input  start, abort, max_cycles, pass_value,
    input  ch_enable, core_out,
    output core_reset, busy, done, pass, timeout,
    output pass_mask, cycle_count
  );

endinterface

// File: rtl/run_ch_monitor.sv
// One core channel: signature compare plus sticky match flag.
// mod is high when the channel no longer blocks a pass.
module run_ch_monitor #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              sample,
  input  logic              ch_en,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] ref_v,
  output logic              flag,
  output logic              mod
);

  logic hit;
  logic match_q, match_d;

  assign hit = (data == ref_v);

  always_comb begin
    match_d = match_q;
    if (clr)
      match_d = 1'b0;
    else if (sample && ch_en && hit)
      match_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      match_q <= 1'b0;
    else
      match_q <= match_d;
  end

  assign flag = match_q;
  assign mod  = !ch_en || match_q || hit;

endmodule

// File: rtl/run_controller.sv
// Sequences cores through reset and run, then stops them on
// an all-channel pass signature, the cycle budget or abort.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  run_controller_if.slave   bus
);

  localparam int RW =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  run_state_e        state_q, state_d;
  logic [RW-1:0]     rcnt_q, rcnt_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  max_q, max_d;
  logic [DATA_W-1:0] pv_q, pv_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic              pass_q, pass_d;
  logic              to_q, to_d;
  logic              crst_q, crst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [NUM_CH-1:0] flag;
  logic [NUM_CH-1:0] mod;
  logic              run, go, stop, clr;
  logic              all_pass, budget_hit;

  assign run  = (state_q == RUN);
  assign go   = bus.start &&
                (state_q == IDLE || state_q == DONE);
  assign stop = bus.abort && (state_q == RESET || run);
  assign clr  = go || stop;

  assign all_pass   = (|en_q) && (&mod);
  assign budget_hit = (|max_q) &&
                      (cyc_q == max_q - CNT_W'(1));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    run_ch_monitor #(.DATA_W(DATA_W)) u_mon (
      .clk    (clk),
      .rst_n  (reset),
      .clr    (clr),
      .sample (run),
      .ch_en  (en_q[i]),
      .data   (bus.core_out[i*DATA_W +: DATA_W]),
      .ref_v  (pv_q),
      .flag   (flag[i]),
      .mod    (mod[i])
    );
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    cyc_d   = cyc_q;
    max_d   = max_q;
    pv_d    = pv_q;
    en_d    = en_q;
    pass_d  = pass_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RESET;
          rcnt_d  = '0;
          cyc_d   = '0;
          max_d   = bus.max_cycles;
          pv_d    = bus.pass_value;
          en_d    = bus.ch_enable;
          pass_d  = 1'b0;
          to_d    = 1'b0;
        end
      end
      RESET: begin
        if (bus.abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
          to_d    = 1'b0;
        end else if (rcnt_q == RW'(RST_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
          to_d    = 1'b0;
        end else begin
          if (!(&cyc_q))
            cyc_d = cyc_q + CNT_W'(1);
          // pass wins over a budget expiring in the same cycle
          if (all_pass) begin
            state_d = DONE;
            pass_d  = 1'b1;
          end else if (budget_hit) begin
            state_d = DONE;
            to_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    crst_d = (state_d != RUN);
    busy_d = (state_d == RESET) || (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      cyc_q   <= '0;
      max_q   <= '0;
      pv_q    <= '0;
      en_q    <= '0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
      crst_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      cyc_q   <= cyc_d;
      max_q   <= max_d;
      pv_q    <= pv_d;
      en_q    <= en_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
      crst_q  <= crst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.core_reset  = crst_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.timeout     = to_q;
  assign bus.pass_mask   = flag;
  assign bus.cycle_count = cyc_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: a 1-channel and a 4-channel
// instance, run results checked against a queue of expectations.
module tb_run_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  run_controller_if #(.DATA_W(32), .NUM_CH(1), .CNT_W(32)) i1 ();
  run_controller_if #(.DATA_W(32), .NUM_CH(4), .CNT_W(32)) i4 ();

  run_controller #(
    .DATA_W(32), .NUM_CH(1), .RST_CYCLES(1), .CNT_W(32)
  ) u1 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (i1.slave)
  );

  run_controller #(
    .DATA_W(32), .NUM_CH(4), .RST_CYCLES(3), .CNT_W(32)
  ) u4 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (i4.slave)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic        pass;
    logic        to;
    logic [3:0]  mask;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail = 0;

  localparam int O_DONE = 0, O_PASS = 1, O_TO = 2, O_MASK = 3;
  localparam int O_CNT = 4, O_CRST = 5, O_BUSY = 6;

  function automatic logic [63:0] obs(input int sel, input int what);
    logic [63:0] v;
    v = '0;
    if (sel == 1) begin
      case (what)
        O_DONE: v = 64'(i1.done);
        O_PASS: v = 64'(i1.pass);
        O_TO:   v = 64'(i1.timeout);
        O_MASK: v = 64'(i1.pass_mask);
        O_CNT:  v = 64'(i1.cycle_count);
        O_CRST: v = 64'(i1.core_reset);
        default: v = 64'(i1.busy);
      endcase
    end else begin
      case (what)
        O_DONE: v = 64'(i4.done);
        O_PASS: v = 64'(i4.pass);
        O_TO:   v = 64'(i4.timeout);
        O_MASK: v = 64'(i4.pass_mask);
        O_CNT:  v = 64'(i4.cycle_count);
        O_CRST: v = 64'(i4.core_reset);
        default: v = 64'(i4.busy);
      endcase
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    exp_t e;
    chk("sb_size", 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int i = 0; i < budget; i++) begin
        if (obs(e.sel, O_DONE) == 64'd1) break;
        step(1);
      end
      chk({e.tag, "_done"}, obs(e.sel, O_DONE), 64'd1);
      chk({e.tag, "_pass"}, obs(e.sel, O_PASS), 64'(e.pass));
      chk({e.tag, "_to"}, obs(e.sel, O_TO), 64'(e.to));
      chk({e.tag, "_mask"}, obs(e.sel, O_MASK), 64'(e.mask));
      chk({e.tag, "_cnt"}, obs(e.sel, O_CNT), 64'(e.cnt));
      chk({e.tag, "_crst"}, obs(e.sel, O_CRST), 64'd1);
      chk({e.tag, "_busy"}, obs(e.sel, O_BUSY), 64'd0);
    end
  endtask

  initial begin
    i1.start = 0; i1.abort = 0; i1.max_cycles = 0;
    i1.pass_value = 0; i1.ch_enable = 0; i1.core_out = 0;
    i4.start = 0; i4.abort = 0; i4.max_cycles = 0;
    i4.pass_value = 0; i4.ch_enable = 0; i4.core_out = 0;
    step(2);
    chk("rst_crst1", obs(1, O_CRST), 64'd1);
    chk("rst_busy1", obs(1, O_BUSY), 64'd0);
    chk("rst_done1", obs(1, O_DONE), 64'd0);
    chk("rst_cnt4", obs(4, O_CNT), 64'd0);
    chk("rst_mask4", obs(4, O_MASK), 64'd0);
    chk("rst_crst4", obs(4, O_CRST), 64'd1);
    rst_n = 1'b1;
    step(1);

    // timeout with the output never matching
    i1.max_cycles = 1000; i1.pass_value = 32'h25;
    i1.ch_enable = 1'b1; i1.core_out = '0;
    sb.push_back('{"t1_timeout", 1, 1'b0, 1'b1, 4'h0, 32'd1000});
    i1.start = 1;
    step(1);
    i1.start = 0;
    chk("t1_c1_crst", obs(1, O_CRST), 64'd1);
    chk("t1_c1_busy", obs(1, O_BUSY), 64'd1);
    step(1);
    chk("t1_c2_crst", obs(1, O_CRST), 64'd0);
    chk("t1_c2_cnt", obs(1, O_CNT), 64'd0);
    wait_done(1100);

    // single channel pass in RUN cycle 40, restarted from DONE
    sb.push_back('{"t2_pass", 1, 1'b1, 1'b0, 4'h1, 32'd41});
    i1.start = 1;
    step(1);
    i1.start = 0;
    step(1);
    step(40);
    chk("t2_cnt40", obs(1, O_CNT), 64'd40);
    i1.core_out = 32'h25;
    step(1);
    i1.core_out = '0;
    wait_done(10);

    // 4 channels, ch2 disabled, staggered one-cycle matches
    i4.max_cycles = 0; i4.pass_value = 32'h25;
    i4.ch_enable = 4'b1011;
    sb.push_back('{"t3_multi", 4, 1'b1, 1'b0, 4'b1011, 32'd13});
    i4.start = 1;
    step(1);
    i4.start = 0;
    chk("t3_c1_crst", obs(4, O_CRST), 64'd1);
    step(2);
    chk("t3_c3_crst", obs(4, O_CRST), 64'd1);
    step(1);
    chk("t3_c4_crst", obs(4, O_CRST), 64'd0);
    chk("t3_c4_cnt", obs(4, O_CNT), 64'd0);
    for (int k = 0; k <= 12; k++) begin
      i4.core_out = '0;
      if (k == 3)  i4.core_out[2*32 +: 32] = 32'h25;
      if (k == 5)  i4.core_out[0*32 +: 32] = 32'h25;
      if (k == 9)  i4.core_out[1*32 +: 32] = 32'h25;
      if (k == 12) i4.core_out[3*32 +: 32] = 32'h25;
      if (k == 6)  chk("t3_mask_k6", obs(4, O_MASK), 64'h1);
      if (k == 10) chk("t3_mask_k10", obs(4, O_MASK), 64'h3);
      step(1);
    end
    i4.core_out = '0;
    wait_done(5);

    // pass and budget expiry in the same cycle
    i4.max_cycles = 10; i4.ch_enable = 4'hF;
    sb.push_back('{"t4_tie", 4, 1'b1, 1'b0, 4'hF, 32'd10});
    i4.start = 1;
    step(1);
    i4.start = 0;
    step(3);
    for (int k = 0; k <= 9; k++) begin
      i4.core_out = (k == 9) ? {4{32'h25}} : '0;
      step(1);
    end
    i4.core_out = '0;
    wait_done(5);

    // abort in RUN cycle 7, then a clean rerun
    i4.max_cycles = 0; i4.ch_enable = 4'hF;
    i4.start = 1;
    step(1);
    i4.start = 0;
    step(3);
    for (int k = 0; k <= 6; k++) begin
      i4.core_out = '0;
      if (k == 2) i4.core_out[0*32 +: 32] = 32'h25;
      step(1);
    end
    i4.core_out = '0;
    chk("t5_cnt7", obs(4, O_CNT), 64'd7);
    chk("t5_mask_pre", obs(4, O_MASK), 64'h1);
    i4.abort = 1;
    step(1);
    i4.abort = 0;
    chk("t5_busy", obs(4, O_BUSY), 64'd0);
    chk("t5_crst", obs(4, O_CRST), 64'd1);
    chk("t5_done", obs(4, O_DONE), 64'd0);
    chk("t5_mask", obs(4, O_MASK), 64'd0);
    chk("t5_pass", obs(4, O_PASS), 64'd0);
    chk("t5_to", obs(4, O_TO), 64'd0);
    step(2);
    chk("t5_idle_busy", obs(4, O_BUSY), 64'd0);
    i4.max_cycles = 5; i4.ch_enable = 4'b0001;
    sb.push_back('{"t5_rerun", 4, 1'b0, 1'b1, 4'h0, 32'd5});
    i4.start = 1;
    step(1);
    i4.start = 0;
    wait_done(20);

    // async reset mid-run, no clock edge in between
    i1.max_cycles = 0; i1.ch_enable = 1'b1; i1.core_out = '0;
    i1.start = 1;
    step(1);
    i1.start = 0;
    step(10);
    chk("t6_busy_pre", obs(1, O_BUSY), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_crst", obs(1, O_CRST), 64'd1);
    chk("t6_busy", obs(1, O_BUSY), 64'd0);
    chk("t6_cnt", obs(1, O_CNT), 64'd0);
    chk("t6_done4", obs(4, O_DONE), 64'd0);
    chk("t6_to4", obs(4, O_TO), 64'd0);
    #2 rst_n = 1'b1;
    step(1);

    // zero enable and zero budget: runs until aborted
    i1.ch_enable = 1'b0; i1.max_cycles = 0;
    i1.pass_value = 32'h0; i1.core_out = '0;
    i1.start = 1;
    step(1);
    i1.start = 0;
    step(300);
    chk("t7_busy", obs(1, O_BUSY), 64'd1);
    chk("t7_done", obs(1, O_DONE), 64'd0);
    chk("t7_cnt", obs(1, O_CNT), 64'd299);
    chk("t7_mask", obs(1, O_MASK), 64'd0);
    i1.abort = 1;
    step(1);
    i1.abort = 0;
    chk("t7_ab_busy", obs(1, O_BUSY), 64'd0);
    chk("t7_ab_crst", obs(1, O_CRST), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
